// File: rtl/fc_pkg.sv
// Shared types and helpers for the transmit-side flow-control scheduler.
//   tlp_type_e    : TLP class, also the index of the queue / credit pool
//   sched_state_e : scheduler FSM states
//   fc_credit_ok  : modular credit gate, true when consuming `need` keeps the
//                   consumed count within half the field range of the limit
//   fc_next_type  : round-robin successor (P -> NP -> CPL -> P)
package fc_pkg;

    localparam int NUM_TYPES = 3;

    typedef enum logic [1:0] {
        P   = 2'd0,
        NP  = 2'd1,
        CPL = 2'd2
    } tlp_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEND = 2'd2
    } sched_state_e;

    // Arguments are zero-extended to 32 bits by the caller; width < 32.
    function automatic logic fc_credit_ok(input logic [31:0] limit,
                                          input logic [31:0] consumed,
                                          input logic [31:0] need,
                                          input int unsigned width);
        logic [31:0] mask;
        logic [31:0] diff;
        mask = (32'd1 << width) - 32'd1;
        diff = (limit - (consumed + need)) & mask;
        return diff <= (32'd1 << (width - 1));
    endfunction

    function automatic logic [1:0] fc_next_type(input logic [1:0] t);
        return (t == 2'd2) ? 2'd0 : t + 2'd1;
    endfunction

endpackage

// File: rtl/fc_credit_check.sv
// Combinational credit gate for one TLP type.
//   hdr_limit/hdr_consumed   : advertised limit and consumed count (HDR_W)
//   data_limit/data_consumed : advertised limit and consumed count (DATA_W)
//   dcred                    : data credits needed by the head TLP (LEN_W)
//   hdr_inf/data_inf         : infinite-credit bypass
//   hdr_ok/data_ok           : head TLP fits in the header / data pool
module fc_credit_check #(
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12,
    parameter int LEN_W  = 10
) (
    input  logic [HDR_W-1:0]  hdr_limit,
    input  logic [HDR_W-1:0]  hdr_consumed,
    input  logic [DATA_W-1:0] data_limit,
    input  logic [DATA_W-1:0] data_consumed,
    input  logic [LEN_W-1:0]  dcred,
    input  logic              hdr_inf,
    input  logic              data_inf,
    output logic              hdr_ok,
    output logic              data_ok
);
    import fc_pkg::*;

    // Every TLP needs exactly one header credit.
    assign hdr_ok = hdr_inf
                  | fc_credit_ok(32'(hdr_limit), 32'(hdr_consumed), 32'd1, HDR_W);

    // A TLP without payload never waits on data credits.
    assign data_ok = data_inf
                   | (dcred == '0)
                   | fc_credit_ok(32'(data_limit), 32'(data_consumed), 32'(dcred), DATA_W);

endmodule

// File: rtl/fc_tlp_scheduler.sv
// Transmit flow-control scheduler for the P / NP / CPL TLP queues.
// Gates each head-of-queue TLP on its credit pool, round-robins among the
// eligible queues, hands one TLP at a time to the transmit datapath and
// tracks credits consumed per type.
//   req_valid/req_dcred/req_ready : queue heads (bit/slice i = type i), pop pulse
//   hdr_limit/data_limit/*_inf    : advertised credits per type
//   tx_start/tx_type/tx_done      : transmit datapath handshake
//   hdr_consumed/data_consumed    : credits consumed per type (wrapping)
//   blocked                       : queues pending but gated by credits
//
// state | meaning
// IDLE  | nothing pending, wait for any req_valid
// ARB   | check credits, grant one eligible queue or report blocked queues
// SEND  | granted TLP in flight, wait for tx_done
module fc_tlp_scheduler #(
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12,
    parameter int LEN_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          req_valid,
    input  logic [3*LEN_W-1:0]  req_dcred,
    output logic [2:0]          req_ready,
    input  logic [3*HDR_W-1:0]  hdr_limit,
    input  logic [3*DATA_W-1:0] data_limit,
    input  logic [2:0]          hdr_inf,
    input  logic [2:0]          data_inf,
    output logic                tx_start,
    output logic [1:0]          tx_type,
    input  logic                tx_done,
    output logic [3*HDR_W-1:0]  hdr_consumed,
    output logic [3*DATA_W-1:0] data_consumed,
    output logic [2:0]          blocked
);
    import fc_pkg::*;

    sched_state_e      state_q, state_d;
    tlp_type_e         rr_last_q, rr_last_d;
    logic [2:0]        req_ready_q, req_ready_d;
    logic              tx_start_q, tx_start_d;
    logic [1:0]        tx_type_q, tx_type_d;
    logic [2:0]        blocked_q, blocked_d;
    logic [HDR_W-1:0]  hdr_cons_q [NUM_TYPES];
    logic [HDR_W-1:0]  hdr_cons_d [NUM_TYPES];
    logic [DATA_W-1:0] data_cons_q [NUM_TYPES];
    logic [DATA_W-1:0] data_cons_d [NUM_TYPES];

    logic [LEN_W-1:0]  dcred [NUM_TYPES];
    logic [2:0]        hdr_ok, data_ok, eligible;
    logic [1:0]        winner, cand;
    logic              found;

    for (genvar g = 0; g < NUM_TYPES; g++) begin : g_type
        assign dcred[g] = req_dcred[g*LEN_W +: LEN_W];

        fc_credit_check #(
            .HDR_W  (HDR_W),
            .DATA_W (DATA_W),
            .LEN_W  (LEN_W)
        ) u_credit_check (
            .hdr_limit     (hdr_limit[g*HDR_W +: HDR_W]),
            .hdr_consumed  (hdr_cons_q[g]),
            .data_limit    (data_limit[g*DATA_W +: DATA_W]),
            .data_consumed (data_cons_q[g]),
            .dcred         (dcred[g]),
            .hdr_inf       (hdr_inf[g]),
            .data_inf      (data_inf[g]),
            .hdr_ok        (hdr_ok[g]),
            .data_ok       (data_ok[g])
        );

        assign hdr_consumed[g*HDR_W +: HDR_W]    = hdr_cons_q[g];
        assign data_consumed[g*DATA_W +: DATA_W] = data_cons_q[g];
    end

    assign eligible = req_valid & hdr_ok & data_ok;

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        tx_type_d   = tx_type_q;
        blocked_d   = blocked_q;
        hdr_cons_d  = hdr_cons_q;
        data_cons_d = data_cons_q;

        // Search starts just after the last winner so every type gets a turn.
        winner = rr_last_q;
        found  = 1'b0;
        cand   = fc_next_type(rr_last_q);
        for (int k = 0; k < NUM_TYPES; k++) begin
            if (!found && eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
            cand = fc_next_type(cand);
        end

        case (state_q)
            IDLE: begin
                if (|req_valid) state_d = ARB;
            end
            ARB: begin
                if (!(|req_valid)) begin
                    state_d   = IDLE;
                    blocked_d = '0;
                end else if (!found) begin
                    blocked_d = req_valid & ~eligible;
                end else begin
                    req_ready_d         = 3'b001 << winner;
                    tx_start_d          = 1'b1;
                    tx_type_d           = winner;
                    hdr_cons_d[winner]  = hdr_cons_q[winner] + HDR_W'(1);
                    data_cons_d[winner] = data_cons_q[winner] + DATA_W'(dcred[winner]);
                    rr_last_d           = tlp_type_e'(winner);
                    blocked_d           = '0;
                    state_d             = SEND;
                end
            end
            SEND: begin
                if (tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_last_q   <= CPL;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_type_q   <= '0;
            blocked_q   <= '0;
            hdr_cons_q  <= '{default: '0};
            data_cons_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            tx_type_q   <= tx_type_d;
            blocked_q   <= blocked_d;
            hdr_cons_q  <= hdr_cons_d;
            data_cons_q <= data_cons_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_type   = tx_type_q;
    assign blocked   = blocked_q;

endmodule

// File: tb/tb_fc_tlp_scheduler.sv
module tb_fc_tlp_scheduler;

    localparam int HDR_W  = 8;
    localparam int DATA_W = 12;
    localparam int LEN_W  = 10;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [2:0]          req_valid;
    logic [3*LEN_W-1:0]  req_dcred;
    logic [2:0]          req_ready;
    logic [3*HDR_W-1:0]  hdr_limit;
    logic [3*DATA_W-1:0] data_limit;
    logic [2:0]          hdr_inf;
    logic [2:0]          data_inf;
    logic                tx_start;
    logic [1:0]          tx_type;
    logic                tx_done;
    logic [3*HDR_W-1:0]  hdr_consumed;
    logic [3*DATA_W-1:0] data_consumed;
    logic [2:0]          blocked;

    fc_tlp_scheduler #(.HDR_W(HDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_dcred     (req_dcred),
        .req_ready     (req_ready),
        .hdr_limit     (hdr_limit),
        .data_limit    (data_limit),
        .hdr_inf       (hdr_inf),
        .data_inf      (data_inf),
        .tx_start      (tx_start),
        .tx_type       (tx_type),
        .tx_done       (tx_done),
        .hdr_consumed  (hdr_consumed),
        .data_consumed (data_consumed),
        .blocked       (blocked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  t;
        logic [7:0]  h;
        logic [11:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] t, input int h, input int d, input int c);
        exp_t e;
        e.t = t;
        e.h = 8'(h);
        e.d = 12'(d);
        e.c = c;
        sb.push_back(e);
    endtask

    // Monitor: every grant seen on the DUT is matched against the scoreboard.
    initial begin
        repeat (3) @(negedge clk);
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 || (req_ready !== 3'b000 && !$isunknown(req_ready))) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant", {31'b0, tx_start}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("grant_tx_start", {31'b0, tx_start}, 32'd1);
                    chk("grant_tx_type", {30'b0, tx_type}, {30'b0, e.t});
                    chk("grant_req_ready", {29'b0, req_ready}, 32'd1 << e.t);
                    chk("grant_hdr_consumed", {24'b0, hdr_consumed[e.t*HDR_W +: HDR_W]}, {24'b0, e.h});
                    chk("grant_data_consumed", {20'b0, data_consumed[e.t*DATA_W +: DATA_W]}, {20'b0, e.d});
                    if (e.c >= 0) chk("grant_cycle", cyc, e.c);
                end
            end
        end
    end

    task automatic wait_start(output int c);
        c = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                c = cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL start_timeout: no tx_start within 20 cycles (cycle %0d)", cyc);
    endtask

    // Pop the granted queue(s) and complete the transfer one cycle after tx_start.
    task automatic finish_tx(input logic [2:0] pop);
        req_valid = req_valid & ~pop;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tx_start"}, {31'b0, tx_start}, 32'd0);
        chk({tag, "_req_ready"}, {29'b0, req_ready}, 32'd0);
        chk({tag, "_tx_type"}, {30'b0, tx_type}, 32'd0);
        chk({tag, "_blocked"}, {29'b0, blocked}, 32'd0);
        chk({tag, "_hdr_consumed"}, {8'b0, hdr_consumed}, 32'd0);
        chk({tag, "_data_consumed_lo"}, {14'b0, data_consumed[17:0]}, 32'd0);
        chk({tag, "_data_consumed_hi"}, {14'b0, data_consumed[35:18]}, 32'd0);
    endtask

    initial begin
        int c;
        int s;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_dcred  = '0;
        hdr_limit  = '0;
        data_limit = '0;
        hdr_inf    = '0;
        data_inf   = '0;
        tx_done    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Exact-fit P grant, then a second P TLP that exceeds both pools.
        hdr_limit[0 +: 8]   = 8'd1;
        data_limit[0 +: 12] = 12'd4;
        req_dcred[0 +: 10]  = 10'd4;
        c = cyc;
        push(2'd0, 1, 4, c + 2);
        req_valid = 3'b001;
        wait_start(s);
        finish_tx(3'b001);
        req_dcred[0 +: 10] = 10'd1;
        req_valid = 3'b001;
        repeat (2) @(negedge clk);
        chk("p_blocked", {29'b0, blocked}, 32'd1);
        @(negedge clk);
        chk("p_blocked_hold", {29'b0, blocked}, 32'd1);
        req_valid = '0;
        @(negedge clk);

        // NP header gating boundary: 0 and 130 block, 129 grants.
        hdr_limit[8 +: 8]    = 8'd0;
        data_limit[12 +: 12] = 12'd100;
        req_dcred[10 +: 10]  = 10'd2;
        req_valid = 3'b010;
        repeat (2) @(negedge clk);
        chk("np_lim0_blocked", {29'b0, blocked}, 32'd2);
        hdr_limit[8 +: 8] = 8'd130;
        @(negedge clk);
        chk("np_lim130_blocked", {29'b0, blocked}, 32'd2);
        hdr_limit[8 +: 8] = 8'd129;
        c = cyc;
        push(2'd1, 1, 2, c + 1);
        wait_start(s);
        req_valid = '0;
        @(negedge clk);
        chk("np_start_pulse", {31'b0, tx_start}, 32'd0);
        chk("np_ready_pulse", {29'b0, req_ready}, 32'd0);
        chk("np_type_held", {30'b0, tx_type}, 32'd1);
        chk("np_blocked_cleared", {29'b0, blocked}, 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;

        // Reset clears counters and restores P as first in round-robin order.
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("reset2");
        rst_n = 1'b1;

        // Round robin over all three queues, P has a second TLP behind the first.
        hdr_limit  = {8'd100, 8'd100, 8'd100};
        data_limit = {12'd1000, 12'd1000, 12'd1000};
        req_dcred  = {10'd1, 10'd1, 10'd1};
        c = cyc;
        push(2'd0, 1, 1, c + 2);
        req_valid = 3'b111;
        wait_start(s);
        push(2'd1, 1, 1, s + 3);
        finish_tx(3'b000);
        wait_start(s);
        push(2'd2, 1, 1, s + 3);
        finish_tx(3'b010);
        wait_start(s);
        push(2'd0, 2, 2, s + 3);
        finish_tx(3'b100);
        wait_start(s);
        finish_tx(3'b001);

        // Infinite P data credits against a zero limit.
        data_inf[0]         = 1'b1;
        data_limit[0 +: 12] = 12'd0;
        req_dcred[0 +: 10]  = 10'd16;
        c = cyc;
        push(2'd0, 3, 18, c + 2);
        req_valid = 3'b001;
        wait_start(s);
        finish_tx(3'b001);
        data_inf = '0;

        // Infinite CPL header credits against a zero limit.
        hdr_inf[2]           = 1'b1;
        hdr_limit[16 +: 8]   = 8'd0;
        req_dcred[20 +: 10]  = 10'd3;
        c = cyc;
        push(2'd2, 2, 4, c + 2);
        req_valid = 3'b100;
        wait_start(s);
        finish_tx(3'b100);
        hdr_inf = '0;

        // NP without payload passes a zero data limit.
        hdr_limit[8 +: 8]    = 8'd100;
        data_limit[12 +: 12] = 12'd0;
        req_dcred[10 +: 10]  = 10'd0;
        c = cyc;
        push(2'd1, 2, 1, c + 2);
        req_valid = 3'b010;
        wait_start(s);
        finish_tx(3'b010);

        // Reset mid-SEND with everything still pending.
        hdr_limit  = {8'd100, 8'd100, 8'd100};
        data_limit = {12'd1000, 12'd1000, 12'd1000};
        req_dcred  = {10'd1, 10'd1, 10'd1};
        c = cyc;
        push(2'd2, 3, 5, c + 2);
        req_valid = 3'b111;
        wait_start(s);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midsend_reset");
        rst_n = 1'b1;
        c = cyc;
        push(2'd0, 1, 1, c + 2);
        wait_start(s);
        finish_tx(3'b111);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
